// File: rtl/login_sequencer.sv
// ---------------------------------------------------------------------------
// login_sequencer
//
// Front-end controller for the lab lock. It collects a 4-character username
// and a 4-character password from a strobed 5-bit character stream. It then
// walks the credential table one entry per cycle and drives the lock. The
// block also owns enrollment writes, consecutive-failure counting and the
// timed lockout.
//
// Ports
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset; also restores the table
//   charValid    1-cycle strobe, charIn holds a character
//   charIn[4:0]  character code
//   backspace    1-cycle strobe, drops the last character (wins over charValid)
//   relock       1-cycle strobe, re-arms the lock or abandons the entry/scan
//   wrEn         enrollment write strobe (dropped while scanning)
//   wrIndex[2:0] table entry to write
//   wrUser[19:0] username, char k in bits [5k+4:5k]
//   wrPass[19:0] password, same packing
//   lock         1 = locked
//   inputCount   characters currently held, 0..8
//   busy         high while scanning the table
//   authFail     1-cycle pulse when an attempt fails
//   lockedOut    high during the lockout period
//   matchIndex   index of the last matching table entry
// ---------------------------------------------------------------------------
module login_sequencer #(
    parameter int NUM_USERS      = 8,
    parameter int MAX_FAILS      = 3,
    parameter int LOCKOUT_CYCLES = 50_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        charValid,
    input  logic [4:0]  charIn,
    input  logic        backspace,
    input  logic        relock,
    input  logic        wrEn,
    input  logic [2:0]  wrIndex,
    input  logic [19:0] wrUser,
    input  logic [19:0] wrPass,
    output logic        lock,
    output logic [3:0]  inputCount,
    output logic        busy,
    output logic        authFail,
    output logic        lockedOut,
    output logic [2:0]  matchIndex
);

    localparam int IDX_W  = 3;
    localparam int CRED_W = 20;
    localparam int LO_W   = 26;
    // One spare bit so the incremented count cannot wrap before the compare.
    localparam int FAIL_W = $clog2(MAX_FAILS + 1) + 1;

    localparam logic [1:0] S_ENTRY    = 2'd0;
    localparam logic [1:0] S_SCAN     = 2'd1;
    localparam logic [1:0] S_UNLOCKED = 2'd2;
    localparam logic [1:0] S_LOCKOUT  = 2'd3;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_USERS - 1);
    localparam logic [LO_W-1:0]  LO_LAST  = LO_W'(LOCKOUT_CYCLES - 1);
    localparam logic [FAIL_W-1:0] FAIL_LIM = FAIL_W'(MAX_FAILS);

    typedef struct packed {
        logic              vld;
        logic [CRED_W-1:0] user;
        logic [CRED_W-1:0] pass;
    } cred_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [CRED_W-1:0] user_q, user_d;
    logic [CRED_W-1:0] pass_q, pass_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [FAIL_W-1:0] fail_q, fail_d, fail_inc;
    logic [LO_W-1:0]   lo_cnt_q, lo_cnt_d;
    logic              lock_q, lock_d;
    logic              auth_q, auth_d;
    logic              busy_q, lockout_q;
    logic [IDX_W-1:0]  match_q, match_d;
    cred_t             tbl_q [NUM_USERS];

    logic              hit;
    logic              wr_ok;

    // The table is only read while scanning, and writes are refused then,
    // so a scan never sees an entry change under it.
    assign wr_ok    = wrEn && (state_q != S_SCAN) && (int'(wrIndex) < NUM_USERS);
    assign hit      = tbl_q[idx_q].vld && (tbl_q[idx_q].user == user_q) &&
                      (tbl_q[idx_q].pass == pass_q);
    assign fail_inc = fail_q + FAIL_W'(1);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        user_d   = user_q;
        pass_d   = pass_q;
        idx_d    = idx_q;
        fail_d   = fail_q;
        lo_cnt_d = lo_cnt_q;
        lock_d   = lock_q;
        auth_d   = 1'b0;
        match_d  = match_q;

        case (state_q)
            S_ENTRY: begin
                if (relock) begin
                    cnt_d = '0;
                end else if (backspace) begin
                    // Backspace beats a simultaneous character; stale
                    // characters stay in the buffer and are overwritten.
                    if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
                end else if (charValid) begin
                    for (int k = 0; k < 4; k++) begin
                        if (cnt_q == 4'(k))     user_d[5*k +: 5] = charIn;
                        if (cnt_q == 4'(k + 4)) pass_d[5*k +: 5] = charIn;
                    end
                    cnt_d = cnt_q + 4'd1;
                    if (cnt_q == 4'd7) begin
                        state_d = S_SCAN;
                        idx_d   = '0;
                    end
                end
            end

            S_SCAN: begin
                // Abort outranks any result of the entry under comparison.
                if (relock) begin
                    state_d = S_ENTRY;
                    cnt_d   = '0;
                end else if (hit) begin
                    state_d = S_UNLOCKED;
                    lock_d  = 1'b0;
                    match_d = idx_q;
                    fail_d  = '0;
                    cnt_d   = '0;
                end else if (idx_q == LAST_IDX) begin
                    auth_d = 1'b1;
                    fail_d = fail_inc;
                    cnt_d  = '0;
                    if (fail_inc >= FAIL_LIM) begin
                        state_d  = S_LOCKOUT;
                        lo_cnt_d = '0;
                    end else begin
                        state_d = S_ENTRY;
                    end
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end

            S_UNLOCKED: begin
                if (relock) begin
                    state_d = S_ENTRY;
                    lock_d  = 1'b1;
                    cnt_d   = '0;
                end
            end

            default: begin // S_LOCKOUT
                lock_d = 1'b1;
                if (lo_cnt_q == LO_LAST) begin
                    state_d  = S_ENTRY;
                    fail_d   = '0;
                    lo_cnt_d = '0;
                end else begin
                    lo_cnt_d = lo_cnt_q + LO_W'(1);
                end
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_ENTRY;
            cnt_q     <= '0;
            user_q    <= '0;
            pass_q    <= '0;
            idx_q     <= '0;
            fail_q    <= '0;
            lo_cnt_q  <= '0;
            lock_q    <= 1'b1;
            auth_q    <= 1'b0;
            busy_q    <= 1'b0;
            lockout_q <= 1'b0;
            match_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            user_q    <= user_d;
            pass_q    <= pass_d;
            idx_q     <= idx_d;
            fail_q    <= fail_d;
            lo_cnt_q  <= lo_cnt_d;
            lock_q    <= lock_d;
            auth_q    <= auth_d;
            // Flags are registered from the next state so they line up
            // with the state they describe.
            busy_q    <= (state_d == S_SCAN);
            lockout_q <= (state_d == S_LOCKOUT);
            match_q   <= match_d;
        end
    end

    // Credential table: entry 0 comes out of reset as a valid all-zero
    // credential, every other entry invalid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_USERS; i++) begin
                tbl_q[i]     <= '0;
                tbl_q[i].vld <= (i == 0);
            end
        end else if (wr_ok) begin
            tbl_q[wrIndex] <= '{vld: 1'b1, user: wrUser, pass: wrPass};
        end
    end

    assign lock       = lock_q;
    assign inputCount = cnt_q;
    assign busy       = busy_q;
    assign authFail   = auth_q;
    assign lockedOut  = lockout_q;
    assign matchIndex = match_q;

endmodule

// File: tb/tb_login_sequencer.sv
module tb_login_sequencer;

    localparam int LO = 20;
    localparam int NU = 8;
    localparam int MF = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        charValid = 1'b0;
    logic [4:0]  charIn = '0;
    logic        backspace = 1'b0;
    logic        relock = 1'b0;
    logic        wrEn = 1'b0;
    logic [2:0]  wrIndex = '0;
    logic [19:0] wrUser = '0;
    logic [19:0] wrPass = '0;
    logic        lock;
    logic [3:0]  inputCount;
    logic        busy;
    logic        authFail;
    logic        lockedOut;
    logic [2:0]  matchIndex;

    login_sequencer #(.NUM_USERS(NU), .MAX_FAILS(MF), .LOCKOUT_CYCLES(LO)) dut (
        .clk(clk), .rst_n(rst_n), .charValid(charValid), .charIn(charIn),
        .backspace(backspace), .relock(relock), .wrEn(wrEn), .wrIndex(wrIndex),
        .wrUser(wrUser), .wrPass(wrPass), .lock(lock), .inputCount(inputCount),
        .busy(busy), .authFail(authFail), .lockedOut(lockedOut),
        .matchIndex(matchIndex)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: the table as plain arrays plus a failure tally.
    bit          m_vld  [NU];
    logic [19:0] m_user [NU];
    logic [19:0] m_pass [NU];
    int          m_fails;

    typedef struct {
        bit   is_match;
        int   idx;
        int   due;
    } exp_t;
    exp_t exp_q[$];
    exp_t e_mon;

    int busy_cycles = 0;
    int lo_cycles   = 0;
    logic prev_lock = 1'b1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: every attempt result (authFail pulse or lock falling) is
    // matched against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            busy_cycles += int'(busy);
            lo_cycles   += int'(lockedOut);
            if (authFail || (prev_lock && !lock)) begin
                chk("event_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    e_mon = exp_q.pop_front();
                    chk("result_kind", !authFail, e_mon.is_match);
                    if (e_mon.is_match) chk("matchIndex", matchIndex, e_mon.idx);
                    chk("result_cycle", cyc, e_mon.due);
                end
            end
        end
        prev_lock = lock;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NU; i++) begin
            m_vld[i]  = (i == 0);
            m_user[i] = '0;
            m_pass[i] = '0;
        end
        m_fails = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; charValid = 0; backspace = 0; relock = 0; wrEn = 0;
        tick();
        tick();
        rst_n = 1'b1;
        exp_q.delete();
        model_reset();
        chk("rst_lock", lock, 1);
        chk("rst_inputCount", inputCount, 0);
        chk("rst_busy", busy, 0);
        chk("rst_authFail", authFail, 0);
        chk("rst_lockedOut", lockedOut, 0);
        chk("rst_matchIndex", matchIndex, 0);
    endtask

    task automatic enroll(input int idx, input logic [19:0] u, input logic [19:0] p);
        wrEn = 1'b1; wrIndex = 3'(idx); wrUser = u; wrPass = p;
        tick();
        wrEn = 1'b0;
        m_vld[idx] = 1'b1; m_user[idx] = u; m_pass[idx] = p;
    endtask

    // mode 0: normal attempt (relock after unlock)
    // mode 1: enrollment write of the same credential into entry wi during scan
    // mode 2: relock during scan
    // mode 3: normal attempt, stay unlocked
    task automatic attempt(input logic [19:0] u, input logic [19:0] p,
                           input bit bs_en, input int mode, input int wi);
        logic [4:0]  want [8];
        logic [4:0]  typed [$];
        logic [19:0] eu, ep;
        int          hit, T;
        exp_t        e;
        for (int k = 0; k < 4; k++) begin
            want[k]     = u[5*k +: 5];
            want[k + 4] = p[5*k +: 5];
        end
        busy_cycles = 0;
        lo_cycles   = 0;
        while (typed.size() < 8) begin
            int r;
            r = bs_en ? int'($urandom_range(0, 7)) : 7;
            if (r == 0) begin
                backspace = 1'b1;
                tick();
                backspace = 1'b0;
                if (typed.size() > 0) void'(typed.pop_back());
            end else if (r == 1) begin
                backspace = 1'b1; charValid = 1'b1; charIn = 5'($urandom);
                tick();
                backspace = 1'b0; charValid = 1'b0;
                if (typed.size() > 0) void'(typed.pop_back());
            end else begin
                charValid = 1'b1; charIn = want[typed.size()];
                tick();
                charValid = 1'b0;
                typed.push_back(charIn);
            end
            chk("inputCount_typing", inputCount, typed.size());
        end
        T = cyc;
        for (int k = 0; k < 4; k++) begin
            eu[5*k +: 5] = typed[k];
            ep[5*k +: 5] = typed[k + 4];
        end
        hit = -1;
        for (int i = NU - 1; i >= 0; i--)
            if (m_vld[i] && m_user[i] == eu && m_pass[i] == ep) hit = i;

        if (mode == 2) begin
            relock = 1'b1;
            tick();
            relock = 1'b0;
            chk("abort_inputCount", inputCount, 0);
            chk("abort_busy", busy, 0);
            repeat (10) tick();
            chk("abort_busy_cycles", busy_cycles, 1);
            return;
        end

        e.is_match = (hit >= 0);
        e.idx      = (hit >= 0) ? hit : 0;
        e.due      = (hit >= 0) ? T + 1 + hit : T + 8;
        exp_q.push_back(e);
        if (mode == 1) begin
            wrEn = 1'b1; wrIndex = 3'(wi); wrUser = eu; wrPass = ep;
            tick();
            wrEn = 1'b0;
        end
        for (int w = 0; w < 20 && exp_q.size() != 0; w++) tick();
        if (exp_q.size() != 0) begin
            chk("outcome_timeout", exp_q.size(), 0);
            exp_q.delete();
        end

        if (hit >= 0) begin
            m_fails = 0;
            chk("unlk_busy_cycles", busy_cycles, hit + 1);
            chk("unlk_inputCount", inputCount, 0);
            chk("unlk_lock", lock, 0);
            if (mode == 3) return;
            if ($urandom_range(0, 1) == 1) begin
                enroll(hit, 20'($urandom), 20'($urandom));
                chk("unlk_write_keeps_lock", lock, 0);
            end
            charValid = 1'b1; charIn = 5'($urandom);
            tick();
            charValid = 1'b0;
            chk("unlk_ignore_char", inputCount, 0);
            relock = 1'b1;
            tick();
            relock = 1'b0;
            chk("relock_lock", lock, 1);
            chk("relock_inputCount", inputCount, 0);
        end else begin
            m_fails++;
            chk("fail_busy_cycles", busy_cycles, 8);
            chk("fail_inputCount", inputCount, 0);
            chk("fail_lockedOut", lockedOut, m_fails >= MF);
            if (m_fails >= MF) begin
                for (int w = 0; w < LO + 10; w++) begin
                    charValid = 1'($urandom_range(0, 1)); charIn = 5'($urandom);
                    backspace = 1'($urandom_range(0, 1));
                    tick();
                    charValid = 1'b0; backspace = 1'b0;
                    if (!lockedOut) break;
                    chk("lockout_ignore_char", inputCount, 0);
                    chk("lockout_lock", lock, 1);
                end
                chk("lockout_len", lo_cycles, LO);
                chk("post_lockout_inputCount", inputCount, 0);
                m_fails = 0;
            end
        end
    endtask

    initial begin
        do_reset();

        // Factory credential in entry 0.
        attempt(20'h0, 20'h0, 0, 0, 0);

        // Enrolled entry 5 found after scanning 0..5.
        enroll(5, 20'h0A5F3, 20'h12345);
        attempt(20'h0A5F3, 20'h12345, 0, 0, 0);

        // Backspace handling.
        backspace = 1'b1; tick(); backspace = 1'b0;
        chk("bs_at_zero", inputCount, 0);
        for (int k = 0; k < 3; k++) begin
            charValid = 1'b1; charIn = 5'(k + 1); tick(); charValid = 1'b0;
        end
        chk("three_chars", inputCount, 3);
        backspace = 1'b1; charValid = 1'b1; tick(); backspace = 1'b0; charValid = 1'b0;
        chk("bs_wins_over_char", inputCount, 2);
        relock = 1'b1; tick(); relock = 1'b0;
        chk("relock_in_entry", inputCount, 0);

        // Dropped write, aborted scan, lockout, then recovery.
        do_reset();
        attempt(20'h11111, 20'h22222, 0, 1, 6);
        attempt(20'h11111, 20'h22222, 0, 0, 0);
        attempt(20'h33333, 20'h44444, 0, 2, 0);
        attempt(20'h55555, 20'h66666, 0, 0, 0);
        attempt(20'h0, 20'h0, 0, 0, 0);

        // Reset while unlocked wipes the enrolled entry.
        enroll(3, 20'hABCDE, 20'h13579);
        attempt(20'hABCDE, 20'h13579, 0, 3, 0);
        do_reset();
        attempt(20'hABCDE, 20'h13579, 0, 0, 0);

        // Randomised traffic.
        for (int it = 0; it < 40; it++) begin
            logic [19:0] u, p;
            int          pick;
            if ($urandom_range(0, 2) == 0)
                enroll(int'($urandom_range(0, NU - 1)), 20'($urandom), 20'($urandom));
            pick = int'($urandom_range(0, NU - 1));
            if (m_vld[pick] && $urandom_range(0, 2) != 0) begin
                u = m_user[pick]; p = m_pass[pick];
            end else begin
                u = 20'($urandom); p = 20'($urandom);
            end
            attempt(u, p, 1'($urandom_range(0, 1)), 0, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/login_sequencer.md
# login_sequencer

Front-end controller for the lab lock. It collects a 4-character username and a 4-character password from a character strobe stream, one 5-bit code per character. It then scans an 8-entry credential table sequentially, one entry per cycle, and drives the `lock` output. It also owns enrollment writes to the table, failed-attempt counting and the timed lockout.

## Interface
Parameters:
- `NUM_USERS`, default 8: credential table depth; index width is 3 bits.
- `MAX_FAILS`, default 3: consecutive failed attempts that trigger lockout.
- `LOCKOUT_CYCLES`, default 50_000_000: lockout duration in clock cycles; held in a 26-bit counter.

Ports:
- `clk` in 1: the single clock; all logic on its rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `charValid` in 1: one-cycle strobe; `charIn` is valid.
- `charIn` in 5: character code.
- `backspace` in 1: one-cycle strobe; removes the last character.
- `relock` in 1: one-cycle strobe; re-arms the lock or abandons the current entry.
- `wrEn` in 1: enrollment write strobe.
- `wrIndex` in 3: table entry to write.
- `wrUser` in 20: username; char k is in bits [5k+4:5k].
- `wrPass` in 20: password; same packing as `wrUser`.
- `lock` out 1: 1 = locked.
- `inputCount` out 4: characters held, 0..8.
- `busy` out 1: high while in SCAN.
- `authFail` out 1: one-cycle pulse when an attempt fails.
- `lockedOut` out 1: high while in LOCKOUT.
- `matchIndex` out 3: index of the last matching table entry.

## Operation
States: ENTRY, SCAN, UNLOCKED, LOCKOUT.

Reset values:
- Outputs: `lock`=1, `inputCount`=0, `busy`=0, `authFail`=0, `lockedOut`=0, `matchIndex`=0.
- Internal: fail counter = 0; state = ENTRY.
- Table: entry 0 = all-zero user and all-zero password, valid; entries 1..7 invalid.

ENTRY:
- An accepted character at count n < 4 is stored as username char n.
- An accepted character at count 4..7 is stored as password char n−4.
- `inputCount` increments by 1 per accepted character.
- `backspace` decrements the count and has no effect at count 0.
- If `charValid` and `backspace` are asserted in the same cycle, backspace wins and the character is dropped.
- When `inputCount` reaches 8, the next state is SCAN with scan index 0.

SCAN:
- Each cycle compares entry [idx]: valid AND user equal AND password equal, over all 20 bits of each.
- On a match: next state UNLOCKED, `lock`=0, `matchIndex`=idx, fail counter cleared, `inputCount` cleared.
- No match at idx 7: `authFail` pulses, fail counter +1, `inputCount` cleared.
  - If the fail counter reaches `MAX_FAILS`, next state is LOCKOUT.
  - Otherwise next state is ENTRY.
- `relock` aborts the scan: next state ENTRY, `inputCount` cleared, fail counter unchanged, no `authFail`.
- `charValid` and `backspace` are ignored.

UNLOCKED:
- `relock` sets `lock`=1, clears `inputCount`, next state ENTRY.
- Characters and backspace are ignored.

LOCKOUT:
- `lockedOut`=1 and `lock`=1.
- A counter runs from 0 to `LOCKOUT_CYCLES`−1, then the next state is ENTRY and the fail counter is cleared.
- `relock`, characters and backspace are ignored.

Relock in ENTRY: discards the partial entry (`inputCount` becomes 0).

Enrollment:
- `wrEn` writes user, password and valid=1 into entry `wrIndex` in any state except SCAN.
- `wrEn` during SCAN is dropped.
- A write to the matched entry while UNLOCKED does not change `lock`.

## Timing
- All outputs are registered.
- The 8th character is accepted at edge T:
  - `inputCount`=8 and `busy`=1 from T+1.
  - Entry i is compared in cycle T+1+i.
  - On a match at entry i, `lock`=0 and `busy`=0 from T+2+i.
  - If no entry matches, `authFail`=1 during cycle T+9 only, and `busy`=0 and `inputCount`=0 from T+9.
- `relock` takes effect at the next edge: `lock`=1 one cycle later.
- Lockout lasts exactly `LOCKOUT_CYCLES` cycles; `lockedOut` falls and the next character is accepted after that.
- Reset mid-operation (`rst_n`=0 sampled at an edge) restores all reset values at that edge, table included.

## Test plan
- Reset, then enter 8 zero characters → `busy` for exactly 1 cycle, `lock`=0, `matchIndex`=0, `authFail` never pulses.
- Enroll entry 5 with user 0x0A5F3 and password 0x12345, enter those 8 characters, then `relock` → entries 0..5 scanned, `lock`=0 at T+7, `matchIndex`=5; after `relock`, `lock`=1 and `inputCount`=0.
- With `LOCKOUT_CYCLES`=20, enter a bad password 3 times → `authFail` pulses at T+9 of each attempt, `lockedOut`=1 for exactly 20 cycles, characters ignored during lockout, then a correct entry unlocks.
- Enter 3 characters, assert `backspace` together with `charValid` → `inputCount` goes 3→2; `backspace` at 0 keeps 0.
- Assert `wrEn` during SCAN with a matching credential → write dropped and the attempt fails; `relock` mid-scan → ENTRY, no `authFail`, fail counter unchanged.
- Assert `rst_n`=0 while UNLOCKED with entry 3 enrolled → `lock`=1, entry 3 invalid, and the old credential fails.
